// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer slice.
//   - Encodings of the external stopwatch FSM state (O_STATE).
//   - Encodings of the command bus into that FSM (I_CMD).
//   - State type of the sequencer's own FSM.
package stopwatch_pkg;

  localparam logic [1:0] ST_RESET = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_TOGGLE = 2'b01;
  localparam logic [1:0] CMD_RESET  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stable counter.
// The debounced level follows the synchronised input only after it has
// differed from the current level for DEB_CYCLES consecutive cycles; any
// bounce restarts the count. A rising debounced level yields a one-cycle press.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   raw      : asynchronous button input
//   level    : debounced level
//   press    : one-cycle pulse on a rising debounced level
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Controller in front of the stopwatch FSM. Debounces the Run/Pause and Reset
// buttons, issues one-cycle commands on I_CMD, confirms each by watching
// O_STATE, and derives TICK / CLEAR for the time-count datapath.
// Ports:
//   CLK, RST         : clock, asynchronous active-high reset
//   BTN_RUN, BTN_RST : raw buttons
//   O_STATE          : FSM state (00 RESET, 01 RUN, 10 PAUSE, 11 illegal)
//   I_CMD            : FSM command (00 none, 01 toggle, 10 reset)
//   TICK             : count-enable pulse every PRESCALE cycles of RUN
//   CLEAR            : one-cycle pulse on entry to RESET
//   BUSY             : sequencer not IDLE
//   ERR              : sticky command-timeout flag
// Build option: define PRESS_QUEUE_EN to keep one press that arrives while
// BUSY and dispatch it once the current command completes.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PRESCALE   = 10,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_RUN,
  input  logic       BTN_RST,
  input  logic [1:0] O_STATE,
  output logic [1:0] I_CMD,
  output logic       TICK,
  output logic       CLEAR,
  output logic       BUSY,
  output logic       ERR
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic run_press, rst_press;
  logic run_level_unused, rst_level_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (BTN_RUN),
    .level (run_level_unused),
    .press (run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (BTN_RST),
    .level (rst_level_unused),
    .press (rst_press)
  );

  seq_state_e    state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [1:0]    exp_q, exp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    prev_q;
  logic          ev_run, ev_rst;

`ifdef PRESS_QUEUE_EN
  logic pend_valid_q, pend_valid_d;
  logic pend_rst_q, pend_rst_d;

  // In IDLE the pending slot is merged with fresh presses and consumed.
  assign ev_rst = rst_press | (pend_valid_q & pend_rst_q);
  assign ev_run = run_press | (pend_valid_q & ~pend_rst_q);

  // A reset press may replace a pending run; a run never replaces anything.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_rst_d   = pend_rst_q;
    if (state_q == IDLE) begin
      pend_valid_d = 1'b0;
      pend_rst_d   = 1'b0;
    end else if (rst_press) begin
      pend_valid_d = 1'b1;
      pend_rst_d   = 1'b1;
    end else if (run_press && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_rst_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_valid_q <= 1'b0;
      pend_rst_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rst_q   <= pend_rst_d;
    end
  end
`else
  assign ev_rst = rst_press;
  assign ev_run = run_press;
`endif

  // State register (with the registers the FSM owns).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      exp_q   <= ST_RESET;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ev_rst) begin
          cmd_d   = CMD_RESET;
          exp_d   = ST_RESET;
          state_d = ISSUE;
        end else if (ev_run) begin
          cmd_d   = CMD_TOGGLE;
          exp_d   = (O_STATE == ST_RUN) ? ST_PAUSE : ST_RUN;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (O_STATE == exp_q) begin
          state_d = IDLE;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    I_CMD = (state_q == ISSUE) ? cmd_q : CMD_NONE;
    BUSY  = (state_q != IDLE);
    ERR   = err_q;
  end

  // Prescaler follows the observed FSM state, not the sequencer.
  always_comb begin
    presc_d = presc_q;
    TICK    = 1'b0;
    if (O_STATE == ST_RUN) begin
      if (presc_q == PRE_LAST) begin
        TICK    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (O_STATE == ST_RESET) begin
      presc_d = '0;
    end
  end

  assign CLEAR = (O_STATE == ST_RESET) && (prev_q != ST_RESET);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      prev_q  <= ST_RESET;
    end else begin
      presc_q <= presc_d;
      prev_q  <= O_STATE;
    end
  end

endmodule
